uart_tx: RTL

//   UART transmitter; upstream partner of the UART receiver. Accepts parallel bytes via valid/ready.

---
 rtl/uart_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART transmitter; valid/ready byte in, start/data(LSB first)/
//            optional parity/stop bits out on a registered, idle-high line.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int P_UART_BUADRATE    = 115200,
  parameter int P_SYSTEM_CLK       = 100000000,
  parameter int P_CLK_DIV          = P_SYSTEM_CLK / P_UART_BUADRATE,
  parameter int P_UART_START_WIDTH = 1,
  parameter int P_UART_DATA_WIDTH  = 8,
  parameter int P_UART_STOP_WIDTH  = 1,
  parameter int P_UART_CHECK_WIDTH = 1,
  parameter int P_UART_CHECK       = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                         i_user_tx_valid,
  output logic                         o_user_tx_ready,
  output logic                         o_uart_tx,
  output logic                         o_tx_busy
);

  localparam int c_BAUD_W   = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
  localparam int c_MAX_SE   = (P_UART_START_WIDTH > P_UART_STOP_WIDTH) ? P_UART_START_WIDTH : P_UART_STOP_WIDTH;
  localparam int c_MAX_DC   = (P_UART_DATA_WIDTH > P_UART_CHECK_WIDTH) ? P_UART_DATA_WIDTH : P_UART_CHECK_WIDTH;
  localparam int c_MAX_BITS = (c_MAX_SE > c_MAX_DC) ? c_MAX_SE : c_MAX_DC;
  localparam int c_BIT_W    = (c_MAX_BITS > 1) ? $clog2(c_MAX_BITS) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(P_CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t                       r_state, w_state_next;
  logic [c_BAUD_W-1:0]          r_baud_cnt, w_baud_cnt_next;
  logic [c_BIT_W-1:0]           r_bit_cnt, w_bit_cnt_next, w_last_cnt;
  logic [P_UART_DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic                         r_parity, w_parity_next;
  logic                         r_tx, w_tx_next;
  logic                         r_ready, r_busy;
  logic                         w_accept, w_baud_end, w_last_bit;

  assign w_accept   = i_user_tx_valid && r_ready;
  assign w_baud_end = (r_baud_cnt == c_BAUD_LAST);
  assign w_last_bit = w_baud_end && (r_bit_cnt == w_last_cnt);

  // Number of bit periods (minus one) the current state occupies.
  always_comb begin
    w_last_cnt = '0;
    case (r_state)
      S_START: w_last_cnt = c_BIT_W'(P_UART_START_WIDTH - 1);
      S_DATA:  w_last_cnt = c_BIT_W'(P_UART_DATA_WIDTH - 1);
      S_CHECK: w_last_cnt = c_BIT_W'(P_UART_CHECK_WIDTH - 1);
      S_STOP:  w_last_cnt = c_BIT_W'(P_UART_STOP_WIDTH - 1);
      default: w_last_cnt = '0;
    endcase
  end

  always_comb begin
    w_state_next    = r_state;
    w_baud_cnt_next = r_baud_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_parity_next   = r_parity;
    if (r_state == S_IDLE) begin
      w_baud_cnt_next = '0;
      w_bit_cnt_next  = '0;
      if (w_accept) begin
        w_state_next  = S_START;
        w_shift_next  = i_user_tx_data;
        w_parity_next = (P_UART_CHECK == 2) ? ~(^i_user_tx_data) : ^i_user_tx_data;
      end
    end else begin
      w_baud_cnt_next = w_baud_end ? '0 : r_baud_cnt + 1'b1;
      if (w_baud_end) begin
        w_bit_cnt_next = w_last_bit ? '0 : r_bit_cnt + 1'b1;
        if (r_state == S_DATA) w_shift_next = r_shift >> 1;
        if (w_last_bit) begin
          case (r_state)
            S_START: w_state_next = S_DATA;
            S_DATA:  w_state_next = (P_UART_CHECK != 0) ? S_CHECK : S_STOP;
            S_CHECK: w_state_next = S_STOP;
            S_STOP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
          endcase
        end
      end
    end
  end

  // Line level is derived from the next state so the register shows it one clock after the edge.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      S_CHECK: w_tx_next = w_parity_next;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
      r_tx       <= w_tx_next;
      r_ready    <= (w_state_next == S_IDLE);
      r_busy     <= (w_state_next != S_IDLE);
    end
  end

  assign o_uart_tx       = r_tx;
  assign o_user_tx_ready = r_ready;
  assign o_tx_busy       = r_busy;

endmodule
`default_nettype wire
